// File: rtl/bcd_clock_core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_clock_core_pkg
// Purpose  : Shared constants and helpers for the BCD clock core: the
//            7-segment code table, the maximum value of a non-top field and
//            the BCD field validity check.
// Ports    : (package - none)
// Revision : 1.0  initial release
// ============================================================================
package bcd_clock_core_pkg;

    // Active-high segment codes {g,f,e,d,c,b,a}; element k is the code of digit k.
    localparam logic [9:0][6:0] c_SEG_TABLE = {
        7'b1101111,   // 9
        7'b1111111,   // 8
        7'b0000111,   // 7
        7'b1111101,   // 6
        7'b1101101,   // 5
        7'b1100110,   // 4
        7'b1001111,   // 3
        7'b1011011,   // 2
        7'b0000110,   // 1
        7'b0111111    // 0
    };

    // Minutes and seconds fields both run 00..59.
    localparam int c_FIELD_MAX = 59;

    // A field is valid when both nibbles are decimal digits and the
    // decimal value does not exceed the field maximum.
    function automatic logic bcd_field_valid(input logic [7:0] field, input int max_val);
        logic digits_ok;
        int   dec_val;
        digits_ok = (field[7:4] <= 4'd9) && (field[3:0] <= 4'd9);
        dec_val   = int'(field[7:4]) * 10 + int'(field[3:0]);
        return digits_ok && (dec_val <= max_val);
    endfunction

    // Non-decimal codes blank the digit.
    function automatic logic [6:0] seg_code(input logic [3:0] digit);
        logic [6:0] code;
        code = 7'b0000000;
        for (int k = 0; k < 10; k++) begin
            if (digit == 4'(k)) begin
                code = c_SEG_TABLE[k];
            end
        end
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_clock_core_field.sv
`default_nettype none
// ============================================================================
// Module   : bcd_field_counter
// Purpose  : One two-digit BCD field counting 00..MAX_VAL with a load path
//            and a carry-out into the next more-significant field.
// Ports    : clk, reset      - clock, asynchronous active-high reset
//            inc             - advance by one this cycle
//            load, load_val  - load a (pre-validated) BCD value
//            value           - current field value (BCD)
//            next_val        - value the field takes if it advances
//            at_max          - field currently holds MAX_VAL
//            carry           - field advances from MAX_VAL to 00
// Revision : 1.0  initial release
// ============================================================================
module bcd_field_counter
    import bcd_clock_core_pkg::*;
#(
    parameter int MAX_VAL = c_FIELD_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] value,
    output logic [7:0] next_val,
    output logic       at_max,
    output logic       carry
);

    localparam logic [7:0] c_MAX_BCD = {4'(MAX_VAL / 10), 4'(MAX_VAL % 10)};

    logic [7:0] r_value;

    assign value  = r_value;
    assign at_max = (r_value == c_MAX_BCD);
    assign carry  = inc & at_max;

    always_comb begin
        next_val = r_value;
        if (r_value == c_MAX_BCD) begin
            next_val = 8'h00;
        end else if (r_value[3:0] == 4'd9) begin
            next_val = {r_value[7:4] + 4'd1, 4'd0};
        end else begin
            next_val = {r_value[7:4], r_value[3:0] + 4'd1};
        end
    end

    // Load wins over an increment in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value <= 8'h00;
        end else if (load) begin
            r_value <= load_val;
        end else if (inc) begin
            r_value <= next_val;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_clock_core.sv
`default_nettype none
// ============================================================================
// Module   : bcd_clock_core
// Purpose  : BCD time-of-day counter (MM:SS or HH:MM:SS) with one-second
//            prescaler, validated time/alarm loads, alarm match pulse and a
//            multiplexed 7-segment display driver.
// Ports    : clk, reset            - clock, asynchronous active-high reset
//            run                   - 1 = count, 0 = hold
//            load, load_time       - time load strobe and value
//            alarm_load/alarm_value- alarm load strobe and value
//            alarm_en              - enables alarm_hit
//            show_alarm            - display alarm (1) or time (0)
//            time_out, alarm_out   - current time / stored alarm (BCD)
//            tick, rollover        - second pulse, all-max-to-zero pulse
//            alarm_hit, load_err   - alarm match pulse, rejected load pulse
//            seg_an, seg_cat       - one-hot digit enable, segment code
// Revision : 1.0  initial release
// ============================================================================
module bcd_clock_core
    import bcd_clock_core_pkg::*;
#(
    parameter int NUM_FIELDS = 2,
    parameter int TOP_MAX    = 59,
    parameter int TICK_DIV   = 100000000,
    parameter int SCAN_DIV   = 100000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    load,
    input  logic [8*NUM_FIELDS-1:0] load_time,
    input  logic                    alarm_load,
    input  logic [8*NUM_FIELDS-1:0] alarm_value,
    input  logic                    alarm_en,
    input  logic                    show_alarm,
    output logic [8*NUM_FIELDS-1:0] time_out,
    output logic [8*NUM_FIELDS-1:0] alarm_out,
    output logic                    tick,
    output logic                    rollover,
    output logic                    alarm_hit,
    output logic                    load_err,
    output logic [2*NUM_FIELDS-1:0] seg_an,
    output logic [6:0]              seg_cat
);

    localparam int W  = 8 * NUM_FIELDS;
    localparam int D  = 2 * NUM_FIELDS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(D);

    localparam logic [PW-1:0] c_PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] c_SCAN_MAX  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] c_IDX_MAX   = IW'(D - 1);

    // ------------------------------------------------------------------
    // Load validation
    // ------------------------------------------------------------------
    logic w_time_valid;
    logic w_alarm_valid;
    logic w_load_ok;

    always_comb begin
        w_time_valid  = 1'b1;
        w_alarm_valid = 1'b1;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (!bcd_field_valid(load_time[8*i +: 8],
                                 (i == NUM_FIELDS - 1) ? TOP_MAX : c_FIELD_MAX)) begin
                w_time_valid = 1'b0;
            end
            if (!bcd_field_valid(alarm_value[8*i +: 8],
                                 (i == NUM_FIELDS - 1) ? TOP_MAX : c_FIELD_MAX)) begin
                w_alarm_valid = 1'b0;
            end
        end
    end

    assign w_load_ok = load & w_time_valid;

    // ------------------------------------------------------------------
    // One-second prescaler
    // ------------------------------------------------------------------
    logic [PW-1:0] r_presc;
    logic          w_tick;
    logic          w_advance;

    // Gating with reset keeps tick low during reset even when TICK_DIV = 1.
    assign w_tick    = run & (r_presc == c_PRESC_MAX) & ~reset;
    // A coincident valid load discards the increment but not the tick.
    assign w_advance = w_tick & ~w_load_ok;
    assign tick      = w_tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (w_load_ok) begin
            r_presc <= '0;
        end else if (run) begin
            r_presc <= (r_presc == c_PRESC_MAX) ? '0 : r_presc + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Field counter chain
    // ------------------------------------------------------------------
    logic [NUM_FIELDS-1:0] w_inc;
    logic [NUM_FIELDS-1:0] w_carry;
    logic [NUM_FIELDS-1:0] w_at_max;
    logic [W-1:0]          w_time;
    logic [W-1:0]          w_time_adv;   // time after this cycle's advance

    for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_field
        logic [7:0] w_next;

        if (i == 0) begin : g_lsb
            assign w_inc[i] = w_advance;
        end else begin : g_chain
            assign w_inc[i] = w_carry[i-1];
        end

        bcd_field_counter #(
            .MAX_VAL ((i == NUM_FIELDS - 1) ? TOP_MAX : c_FIELD_MAX)
        ) u_field (
            .clk      (clk),
            .reset    (reset),
            .inc      (w_inc[i]),
            .load     (w_load_ok),
            .load_val (load_time[8*i +: 8]),
            .value    (w_time[8*i +: 8]),
            .next_val (w_next),
            .at_max   (w_at_max[i]),
            .carry    (w_carry[i])
        );

        assign w_time_adv[8*i +: 8] = w_inc[i] ? w_next : w_time[8*i +: 8];
    end

    assign time_out = w_time;
    // The top field only carries when every lower field was also at max.
    assign rollover = w_carry[NUM_FIELDS-1];

    // ------------------------------------------------------------------
    // Alarm register, alarm match and load error pulses
    // ------------------------------------------------------------------
    logic [W-1:0] r_alarm;
    logic         r_alarm_hit;
    logic         r_load_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alarm     <= '0;
            r_alarm_hit <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            if (alarm_load && w_alarm_valid) begin
                r_alarm <= alarm_value;
            end
            // Only a tick-driven advance can hit; a load into the alarm
            // value never does.
            r_alarm_hit <= alarm_en & w_advance & (w_time_adv == r_alarm);
            r_load_err  <= (load & ~w_time_valid) | (alarm_load & ~w_alarm_valid);
        end
    end

    assign alarm_out = r_alarm;
    assign alarm_hit = r_alarm_hit;
    assign load_err  = r_load_err;

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    logic [SW-1:0] r_scan_cnt;
    logic [IW-1:0] r_scan_idx;
    logic [IW-1:0] w_idx_next;
    logic          w_scan_wrap;
    logic [W-1:0]  w_src;
    logic [3:0]    w_digit;
    logic [6:0]    r_seg_cat;

    assign w_scan_wrap = (r_scan_cnt == c_SCAN_MAX);
    assign w_src       = show_alarm ? r_alarm : w_time;

    always_comb begin
        w_idx_next = r_scan_idx;
        if (w_scan_wrap) begin
            w_idx_next = (r_scan_idx == c_IDX_MAX) ? '0 : r_scan_idx + 1'b1;
        end
    end

    // The segment register is loaded with the digit the index is moving to,
    // so seg_cat and seg_an change on the same edge.
    always_comb begin
        w_digit = 4'd0;
        for (int k = 0; k < D; k++) begin
            if (w_idx_next == IW'(k)) begin
                w_digit = w_src[4*k +: 4];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scan_cnt <= '0;
            r_scan_idx <= '0;
            r_seg_cat  <= c_SEG_TABLE[0];
        end else begin
            r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + 1'b1;
            r_scan_idx <= w_idx_next;
            r_seg_cat  <= seg_code(w_digit);
        end
    end

    always_comb begin
        seg_an = '0;
        for (int k = 0; k < D; k++) begin
            seg_an[k] = (r_scan_idx == IW'(k));
        end
    end

    assign seg_cat = r_seg_cat;

endmodule
`default_nettype wire

// File: tb/tb_bcd_clock_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_clock_core
// Purpose  : Directed self-checking bench. dut_a is an MM:SS core with a
//            4-clock second; dut_b is an HH:MM:SS 24-hour core with a
//            2-clock display slot. Steps are referenced to falling edges
//            n<k> (dut_a) and m<k> (dut_b) counted from reset release.
// Revision : 1.0  initial release
// ============================================================================
module tb_bcd_clock_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int hits;

    // ---------------- dut_a : MM:SS ----------------
    logic        a_reset, a_run, a_load, a_alarm_load, a_alarm_en, a_show_alarm;
    logic [15:0] a_load_time, a_alarm_value, a_time_out, a_alarm_out;
    logic        a_tick, a_rollover, a_alarm_hit, a_load_err;
    logic [3:0]  a_seg_an;
    logic [6:0]  a_seg_cat;

    bcd_clock_core #(
        .NUM_FIELDS (2), .TOP_MAX (59), .TICK_DIV (4), .SCAN_DIV (2)
    ) dut_a (
        .clk (clk), .reset (a_reset), .run (a_run),
        .load (a_load), .load_time (a_load_time),
        .alarm_load (a_alarm_load), .alarm_value (a_alarm_value),
        .alarm_en (a_alarm_en), .show_alarm (a_show_alarm),
        .time_out (a_time_out), .alarm_out (a_alarm_out),
        .tick (a_tick), .rollover (a_rollover),
        .alarm_hit (a_alarm_hit), .load_err (a_load_err),
        .seg_an (a_seg_an), .seg_cat (a_seg_cat)
    );

    // ---------------- dut_b : HH:MM:SS ----------------
    logic        b_reset, b_run, b_load, b_alarm_load, b_alarm_en, b_show_alarm;
    logic [23:0] b_load_time, b_alarm_value, b_time_out, b_alarm_out;
    logic        b_tick, b_rollover, b_alarm_hit, b_load_err;
    logic [5:0]  b_seg_an;
    logic [6:0]  b_seg_cat;

    bcd_clock_core #(
        .NUM_FIELDS (3), .TOP_MAX (23), .TICK_DIV (4), .SCAN_DIV (2)
    ) dut_b (
        .clk (clk), .reset (b_reset), .run (b_run),
        .load (b_load), .load_time (b_load_time),
        .alarm_load (b_alarm_load), .alarm_value (b_alarm_value),
        .alarm_en (b_alarm_en), .show_alarm (b_show_alarm),
        .time_out (b_time_out), .alarm_out (b_alarm_out),
        .tick (b_tick), .rollover (b_rollover),
        .alarm_hit (b_alarm_hit), .load_err (b_load_err),
        .seg_an (b_seg_an), .seg_cat (b_seg_cat)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        case (d)
            4'd0: ref_seg = 7'b0111111;
            4'd1: ref_seg = 7'b0000110;
            4'd2: ref_seg = 7'b1011011;
            4'd3: ref_seg = 7'b1001111;
            4'd4: ref_seg = 7'b1100110;
            4'd5: ref_seg = 7'b1101101;
            4'd6: ref_seg = 7'b1111101;
            4'd7: ref_seg = 7'b0000111;
            4'd8: ref_seg = 7'b1111111;
            4'd9: ref_seg = 7'b1101111;
            default: ref_seg = 7'b0000000;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [23:0] alarm_ref;
        int          idx;

        alarm_ref = 24'h123456;

        a_reset = 1'b1; a_run = 1'b1; a_load = 1'b0; a_load_time = '0;
        a_alarm_load = 1'b0; a_alarm_value = '0; a_alarm_en = 1'b0; a_show_alarm = 1'b0;
        b_reset = 1'b1; b_run = 1'b0; b_load = 1'b0; b_load_time = '0;
        b_alarm_load = 1'b0; b_alarm_value = '0; b_alarm_en = 1'b0; b_show_alarm = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        chk("rst_time",     a_time_out,  32'h0);
        chk("rst_alarm",    a_alarm_out, 32'h0);
        chk("rst_tick",     a_tick,      32'h0);
        chk("rst_rollover", a_rollover,  32'h0);
        chk("rst_hit",      a_alarm_hit, 32'h0);
        chk("rst_err",      a_load_err,  32'h0);
        chk("rst_an",       a_seg_an,    32'b0001);
        chk("rst_cat",      a_seg_cat,   32'b0111111);
        a_reset = 1'b0;                                          // n0

        // ---------------- scenario 1: free-running count ----------------
        repeat (2) @(negedge clk);                               // n2
        chk("s1_no_tick_early", a_tick, 32'h0);
        @(negedge clk);                                          // n3
        chk("s1_first_tick", a_tick, 32'h1);
        @(negedge clk);                                          // n4
        chk("s1_tick_one_cycle", a_tick, 32'h0);
        chk("s1_time_after_1", a_time_out, 32'h0001);
        repeat (35) @(negedge clk);                              // n39
        chk("s1_tenth_tick", a_tick, 32'h1);
        @(negedge clk);                                          // n40
        chk("s1_time_after_10", a_time_out, 32'h0010);

        // ---------------- scenario 2: rollover ----------------
        a_load = 1'b1; a_load_time = 16'h5958;
        @(negedge clk);                                          // n41
        a_load = 1'b0;
        chk("s2_loaded", a_time_out, 32'h5958);
        chk("s2_no_err", a_load_err, 32'h0);
        repeat (3) @(negedge clk);                               // n44
        chk("s2_tick1", a_tick, 32'h1);
        chk("s2_no_rollover_yet", a_rollover, 32'h0);
        @(negedge clk);                                          // n45
        chk("s2_time_5959", a_time_out, 32'h5959);
        repeat (3) @(negedge clk);                               // n48
        chk("s2_tick2", a_tick, 32'h1);
        chk("s2_rollover", a_rollover, 32'h1);
        @(negedge clk);                                          // n49
        chk("s2_time_0000", a_time_out, 32'h0000);
        chk("s2_rollover_clear", a_rollover, 32'h0);

        // ---------------- scenario 3: rejected loads ----------------
        a_run = 1'b0;
        a_load = 1'b1; a_load_time = 16'h0A00;
        @(negedge clk);                                          // n50
        a_load = 1'b0;
        chk("s3_err_0A00", a_load_err, 32'h1);
        chk("s3_time_kept_0A00", a_time_out, 32'h0000);
        @(negedge clk);                                          // n51
        chk("s3_err_pulse_end", a_load_err, 32'h0);
        a_load = 1'b1; a_load_time = 16'h6000;
        @(negedge clk);                                          // n52
        a_load = 1'b0;
        chk("s3_err_6000", a_load_err, 32'h1);
        chk("s3_time_kept_6000", a_time_out, 32'h0000);
        @(negedge clk);                                          // n53
        chk("s3_err_end_6000", a_load_err, 32'h0);
        a_alarm_load = 1'b1; a_alarm_value = 16'h0070;
        @(negedge clk);                                          // n54
        a_alarm_load = 1'b0;
        chk("s3_err_alarm_0070", a_load_err, 32'h1);
        chk("s3_alarm_kept", a_alarm_out, 32'h0000);
        @(negedge clk);                                          // n55
        chk("s3_err_end_alarm", a_load_err, 32'h0);
        a_load = 1'b1; a_load_time = 16'h0A00;
        a_alarm_load = 1'b1; a_alarm_value = 16'h0070;
        @(negedge clk);                                          // n56
        a_load = 1'b0; a_alarm_load = 1'b0;
        chk("s3_err_both", a_load_err, 32'h1);
        @(negedge clk);                                          // n57
        chk("s3_err_both_single", a_load_err, 32'h0);
        a_alarm_load = 1'b1; a_alarm_value = 16'h0003;
        @(negedge clk);                                          // n58
        a_alarm_load = 1'b0;
        chk("s4_alarm_stored", a_alarm_out, 32'h0003);
        chk("s4_valid_alarm_no_err", a_load_err, 32'h0);

        // ---------------- scenario 4: alarm ----------------
        a_run = 1'b1; a_alarm_en = 1'b1;
        repeat (11) @(negedge clk);                              // n69
        chk("s4_third_tick", a_tick, 32'h1);
        chk("s4_time_before", a_time_out, 32'h0002);
        chk("s4_no_hit_before", a_alarm_hit, 32'h0);
        @(negedge clk);                                          // n70
        chk("s4_time_match", a_time_out, 32'h0003);
        chk("s4_hit", a_alarm_hit, 32'h1);
        @(negedge clk);                                          // n71
        chk("s4_hit_one_cycle", a_alarm_hit, 32'h0);

        a_alarm_en = 1'b0;
        a_load = 1'b1; a_load_time = 16'h0000;
        @(negedge clk);                                          // n72
        a_load = 1'b0;
        hits = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            hits += int'(a_alarm_hit);
        end                                                      // n86
        chk("s4_disabled_time", a_time_out, 32'h0003);
        chk("s4_disabled_no_hit", hits, 32'd0);

        a_alarm_en = 1'b1;
        a_load = 1'b1; a_load_time = 16'h0003;
        @(negedge clk);                                          // n87
        a_load = 1'b0;
        chk("s4_direct_load", a_time_out, 32'h0003);
        hits = int'(a_alarm_hit);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            hits += int'(a_alarm_hit);
        end                                                      // n90
        chk("s4_load_no_hit", hits, 32'd0);

        // ---------------- scenario 5: load vs tick, async reset ----------------
        chk("s5_tick_with_load", a_tick, 32'h1);
        a_load = 1'b1; a_load_time = 16'h1234;
        @(negedge clk);                                          // n91
        a_load = 1'b0;
        chk("s5_load_wins", a_time_out, 32'h1234);
        repeat (2) @(negedge clk);                               // n93
        chk("s5_presc_restart_no_tick", a_tick, 32'h0);
        @(negedge clk);                                          // n94
        chk("s5_presc_restart_tick", a_tick, 32'h1);
        @(negedge clk);                                          // n95
        chk("s5_count_on", a_time_out, 32'h1235);
        a_load = 1'b1; a_load_time = 16'h0A00;
        @(negedge clk);                                          // n96
        a_load = 1'b0;
        chk("s5_err_pending", a_load_err, 32'h1);
        #2 a_reset = 1'b1;
        #1;
        chk("s5_async_time",     a_time_out,  32'h0);
        chk("s5_async_alarm",    a_alarm_out, 32'h0);
        chk("s5_async_tick",     a_tick,      32'h0);
        chk("s5_async_rollover", a_rollover,  32'h0);
        chk("s5_async_hit",      a_alarm_hit, 32'h0);
        chk("s5_async_err",      a_load_err,  32'h0);
        chk("s5_async_an",       a_seg_an,    32'b0001);
        chk("s5_async_cat",      a_seg_cat,   32'b0111111);
        repeat (2) @(negedge clk);                               // n98
        a_reset = 1'b0;
        repeat (3) @(negedge clk);                               // n101
        chk("s5_resume_tick", a_tick, 32'h1);
        @(negedge clk);                                          // n102
        chk("s5_resume_time", a_time_out, 32'h0001);

        // ---------------- scenario 6: HH:MM:SS and display scan ----------------
        b_reset = 1'b0;                                          // m0
        b_load = 1'b1; b_load_time = 24'h235959;
        b_alarm_load = 1'b1; b_alarm_value = alarm_ref;
        b_show_alarm = 1'b1;
        @(negedge clk);                                          // m1
        b_load = 1'b0; b_alarm_load = 1'b0;
        chk("s6_loaded", b_time_out, 32'h235959);
        chk("s6_alarm", b_alarm_out, 32'h123456);
        b_run = 1'b1;
        repeat (3) @(negedge clk);                               // m4
        chk("s6_tick", b_tick, 32'h1);
        chk("s6_rollover", b_rollover, 32'h1);
        @(negedge clk);                                          // m5
        chk("s6_time_zero", b_time_out, 32'h000000);
        for (int j = 5; j < 17; j++) begin
            idx = (j / 2) % 6;
            chk("s6_scan_an", b_seg_an, 32'(6'b000001 << idx));
            chk("s6_scan_cat", b_seg_cat, 32'(ref_seg(alarm_ref[4*idx +: 4])));
            @(negedge clk);
        end                                                      // m17
        b_show_alarm = 1'b0;
        @(negedge clk);                                          // m18
        chk("s6_time_src_an", b_seg_an, 32'b001000);
        chk("s6_time_src_cat", b_seg_cat, 32'b0111111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
